// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Purpose  : Shared operation codes and FSM state encoding for md_unit.
// Revision : 1.0
// ============================================================================
package md_unit_pkg;

    // Values match the decode control unit's md operation encoding
    localparam logic [2:0] MD_MFHI  = 3'd0;
    localparam logic [2:0] MD_MFLO  = 3'd1;
    localparam logic [2:0] MD_MTHI  = 3'd2;
    localparam logic [2:0] MD_MTLO  = 3'd3;
    localparam logic [2:0] MD_MULT  = 3'd4;
    localparam logic [2:0] MD_MULTU = 3'd5;
    localparam logic [2:0] MD_DIV   = 3'd6;
    localparam logic [2:0] MD_DIVU  = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage : md_unit_pkg
`default_nettype wire

// File: rtl/md_step.sv
`default_nettype none
// ============================================================================
// Module   : md_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module md_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              qbit_o
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    always_comb begin
        w_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
        w_shift = acc_i[2*XLEN-1:XLEN-1];
        w_ge    = (w_shift >= {1'b0, opd_i});
        // Only used when w_ge holds, where the true difference fits in XLEN bits
        w_diff  = w_shift[XLEN-1:0] - opd_i;
        acc_o   = '0;
        qbit_o  = 1'b0;
        if (is_div_i) begin
            qbit_o = w_ge;
            if (w_ge) begin
                acc_o = {w_diff, acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {w_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {w_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule : md_step
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Revision : 1.0
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            cancel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rdata
);

    localparam int CW = $clog2(XLEN);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic              is_div_q, is_div_d;
    logic              sgn_q, sgn_d;
    logic              rsgn_q, rsgn_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic [2*XLEN-1:0] w_step_acc;
    logic              w_qbit;
    logic              w_signed;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    md_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (w_step_acc),
        .qbit_o   (w_qbit)
    );

    always_comb begin
        w_signed = ~op[0];
        w_a_mag  = (w_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
        w_b_mag  = (w_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
        w_prod   = sgn_q  ? (~acc_q + 1'b1) : acc_q;
        w_quot   = sgn_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        w_rem    = rsgn_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        araw_d   = araw_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        rsgn_d   = rsgn_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        MD_MFHI, MD_MFLO: ;
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: begin
                            state_d  = MD_CALC;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            araw_d   = a;
                            dz_d     = (b == '0);
                            sgn_d    = w_signed & (a[XLEN-1] ^ b[XLEN-1]);
                            rsgn_d   = w_signed & a[XLEN-1];
                            // Divide shifts the dividend out of the low half;
                            // multiply consumes the multiplier from the low half.
                            if (op[1]) begin
                                acc_d = {{XLEN{1'b0}}, w_a_mag};
                                opd_d = w_b_mag;
                            end else begin
                                acc_d = {{XLEN{1'b0}}, w_b_mag};
                                opd_d = w_a_mag;
                            end
                        end
                    endcase
                end
            end
            MD_CALC: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = MD_FIX;
                    end
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = w_prod[2*XLEN-1:XLEN];
                        lo_d = w_prod[XLEN-1:0];
                    end else if (dz_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = w_rem;
                        lo_d = w_quot;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            rsgn_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            araw_q   <= araw_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            rsgn_q   <= rsgn_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != MD_IDLE);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = op[0] ? lo_q : hi_q;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed self-checking bench for md_unit.
// Revision : 1.0
// ============================================================================
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_checks;
    int n_errors;

    md_unit #(
        .XLEN (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 60) begin
            cyc++;
            tick();
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        issue(o, av, bv);
        wait_idle(cyc);
        check({tag, " busy cycles"}, 64'(cyc), 64'd33);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
        op = 3'd0;
        tick();
        check({tag, " done clear"}, {63'd0, done}, 64'd0);
        check({tag, " mfhi"}, {32'd0, rdata}, {32'd0, eh});
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        cancel = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // mthi then mfhi/mflo
        issue(3'd2, 32'h1234_5678, 32'd0);
        check("mthi busy", {63'd0, busy}, 64'd0);
        check("mthi hi", {32'd0, hi}, 64'h1234_5678);
        check("mthi lo", {32'd0, lo}, 64'd0);
        op = 3'd0;
        #1;
        check("mfhi rdata", {32'd0, rdata}, 64'h1234_5678);
        op = 3'd1;
        #1;
        check("mflo rdata", {32'd0, rdata}, 64'd0);
        tick();
        check("mthi busy later", {63'd0, busy}, 64'd0);

        run_md("mult", 3'd4, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu by0", 3'd7, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_md("div ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Cancel mid-multiply
        issue(3'd4, 32'd5, 32'd7);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", {63'd0, busy}, 64'd0);
        check("cancel done", {63'd0, done}, 64'd0);
        check("cancel hi", {32'd0, hi}, 64'd0);
        check("cancel lo", {32'd0, lo}, 64'h8000_0000);
        tick();
        check("cancel no done", {63'd0, done}, 64'd0);

        // cancel beats a simultaneous mtlo
        cancel = 1'b1;
        issue(3'd3, 32'h0000_DEAD, 32'd0);
        cancel = 1'b0;
        check("cancel+mtlo lo", {32'd0, lo}, 64'h8000_0000);

        run_md("reissue", 3'd4, 32'd5, 32'd7, 32'd0, 32'd35);

        // mtlo while busy is ignored
        issue(3'd7, 32'd1000, 32'd7);
        repeat (4) tick();
        start = 1'b1;
        op    = 3'd3;
        a     = 32'h0000_0BAD;
        tick();
        start = 1'b0;
        check("busy mtlo lo", {32'd0, lo}, 64'd35);
        wait_idle(cyc);
        check("divu busy cycles", 64'(cyc + 5), 64'd33);
        check("divu done", {63'd0, done}, 64'd1);
        check("divu lo", {32'd0, lo}, 64'd142);
        check("divu hi", {32'd0, hi}, 64'd6);

        // Asynchronous reset mid-divide
        issue(3'd7, 32'd1000, 32'd7);
        repeat (19) tick();
        check("pre-rst busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {63'd0, busy}, 64'd0);
        check("async rst done", {63'd0, done}, 64'd0);
        check("async rst hi", {32'd0, hi}, 64'd0);
        check("async rst lo", {32'd0, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post-rst busy", {63'd0, busy}, 64'd0);
        check("post-rst done", {63'd0, done}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_md_unit
`default_nettype wire
